// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: FSM state type and default sizing.
package counter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } tc_state_e;

    localparam int DEF_WIDTH      = 9;
    localparam int DEF_EXPECTED   = 512;
    localparam int DEF_LOCK_COUNT = 3;

endpackage

// File: rtl/interval_timer.sv
// Interval counter with clear/increment controls and a flag one step before overflow.
module interval_timer
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH:0]   cnt,
    output logic             sat
);

    // Saturation point is 2**(WIDTH+1)-2 so cnt+1 never wraps.
    localparam logic [WIDTH:0] SAT_V = {{WIDTH{1'b1}}, 1'b0};

    logic [WIDTH:0] cnt_q;
    logic [WIDTH:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = (cnt_q == SAT_V);

endmodule

// File: rtl/tc_period_checker.sv
// Measures the spacing of terminal-count pulses and reports mismatch, timeout and lock.
module tc_period_checker
    import counter_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int EXPECTED   = DEF_EXPECTED,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pulse_in,
    output logic [WIDTH:0]   period_out,
    output logic             period_valid,
    output logic             period_err,
    output logic             locked
);

    localparam int MW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [WIDTH:0] EXP_V  = (WIDTH + 1)'(EXPECTED);
    localparam logic [MW-1:0]  LOCK_V = MW'(LOCK_COUNT);

    tc_state_e       state_q, state_d;
    logic [WIDTH:0]  period_out_q, period_out_d;
    logic            period_valid_q, period_valid_d;
    logic            period_err_q, period_err_d;
    logic            locked_q, locked_d;
    logic [MW-1:0]   match_q, match_d;
    logic [MW-1:0]   match_inc;

    logic            tmr_clear;
    logic            tmr_inc;
    logic [WIDTH:0]  cnt;
    logic            sat;
    logic [WIDTH:0]  cnt_p1;

    interval_timer #(
        .WIDTH (WIDTH)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (tmr_clear),
        .inc   (tmr_inc),
        .cnt   (cnt),
        .sat   (sat)
    );

    assign cnt_p1    = cnt + 1'b1;
    assign match_inc = (match_q == LOCK_V) ? match_q : match_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        period_out_d   = period_out_q;
        period_valid_d = 1'b0;
        period_err_d   = 1'b0;
        locked_d       = locked_q;
        match_d        = match_q;
        tmr_clear      = 1'b0;
        tmr_inc        = 1'b0;

        if (!enable) begin
            state_d   = IDLE;
            tmr_clear = 1'b1;
            match_d   = '0;
            locked_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    tmr_clear = 1'b1;
                    if (pulse_in) begin
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (pulse_in) begin
                        period_out_d   = cnt_p1;
                        period_valid_d = 1'b1;
                        tmr_clear      = 1'b1;
                        if (cnt_p1 == EXP_V) begin
                            match_d  = match_inc;
                            locked_d = (match_inc == LOCK_V);
                        end else begin
                            period_err_d = 1'b1;
                            match_d      = '0;
                            locked_d     = 1'b0;
                        end
                    end else if (sat) begin
                        // No pulse before the counter would overflow: give up and re-arm.
                        period_err_d = 1'b1;
                        match_d      = '0;
                        locked_d     = 1'b0;
                        tmr_clear    = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        tmr_inc = 1'b1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    tmr_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            period_out_q   <= '0;
            period_valid_q <= 1'b0;
            period_err_q   <= 1'b0;
            locked_q       <= 1'b0;
            match_q        <= '0;
        end else begin
            state_q        <= state_d;
            period_out_q   <= period_out_d;
            period_valid_q <= period_valid_d;
            period_err_q   <= period_err_d;
            locked_q       <= locked_d;
            match_q        <= match_d;
        end
    end

    assign period_out   = period_out_q;
    assign period_valid = period_valid_q;
    assign period_err   = period_err_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_tc_period_checker.sv
// Scoreboard bench for tc_period_checker with directed pulse sequences.
module tb_tc_period_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       pulse_in;
    logic [9:0] period_out;
    logic       period_valid;
    logic       period_err;
    logic       locked;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         cyc;
        logic [9:0] pout;
        logic       v;
        logic       e;
        logic       lk;
    } exp_t;

    exp_t sb[$];

    tc_period_checker dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .pulse_in     (pulse_in),
        .period_out   (period_out),
        .period_valid (period_valid),
        .period_err   (period_err),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (period_valid || period_err) begin
            exp_t x;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe: cyc=%0d out=%0d v=%0b e=%0b, want none",
                         cyc, period_out, period_valid, period_err);
            end else begin
                x = sb.pop_front();
                if (x.cyc != cyc || x.pout != period_out || x.v != period_valid ||
                    x.e != period_err || x.lk != locked) begin
                    bad++;
                    $display("FAIL strobe: got cyc=%0d out=%0d v=%0b e=%0b lk=%0b, want cyc=%0d out=%0d v=%0b e=%0b lk=%0b",
                             cyc, period_out, period_valid, period_err, locked,
                             x.cyc, x.pout, x.v, x.e, x.lk);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic gap(input int n);
        pulse_in = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pls(input bit strobe, input int pout, input bit v, input bit e, input bit lk);
        exp_t x;
        if (strobe) begin
            x.cyc  = cyc + 1;
            x.pout = 10'(pout);
            x.v    = v;
            x.e    = e;
            x.lk   = lk;
            sb.push_back(x);
        end
        pulse_in = 1'b1;
        @(posedge clk);
        #1;
        pulse_in = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_out"}, int'(period_out), 0);
        chk({name, "_v"}, int'(period_valid), 0);
        chk({name, "_e"}, int'(period_err), 0);
        chk({name, "_lk"}, int'(locked), 0);
    endtask

    initial begin
        exp_t tx;
        reset    = 1'b1;
        enable   = 1'b1;
        pulse_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;

        // Three matching intervals: lock on the third strobe.
        gap(9);
        pls(0, 0, 0, 0, 0);
        gap(511); pls(1, 512, 1, 0, 0);
        gap(511); pls(1, 512, 1, 0, 0);
        gap(511); pls(1, 512, 1, 0, 1);
        chk("locked_after3", int'(locked), 1);

        // Short interval while locked.
        gap(510); pls(1, 511, 1, 1, 0);
        chk("unlock_short", int'(locked), 0);

        // Relock, then drop enable on a pulse cycle.
        gap(511); pls(1, 512, 1, 0, 0);
        gap(511); pls(1, 512, 1, 0, 0);
        gap(511); pls(1, 512, 1, 0, 1);
        gap(511);
        enable   = 1'b0;
        pulse_in = 1'b1;
        @(posedge clk);
        #1;
        enable   = 1'b1;
        pulse_in = 1'b0;
        chk("en_drop_lk", int'(locked), 0);
        chk("en_drop_out", int'(period_out), 512);

        // Timeout: arm (state is IDLE) then stay silent.
        gap(3);
        pls(0, 0, 0, 0, 0);
        tx.cyc  = cyc + 1023;
        tx.pout = 10'd512;
        tx.v    = 1'b0;
        tx.e    = 1'b1;
        tx.lk   = 1'b0;
        sb.push_back(tx);
        gap(1100);
        chk("timeout_out", int'(period_out), 512);
        pls(0, 0, 0, 0, 0);
        gap(511); pls(1, 512, 1, 0, 0);

        // Back-to-back pulses.
        pls(1, 1, 1, 1, 0);

        // Reset in the middle of a measurement.
        gap(300);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_zero("midreset");
        gap(211);
        pls(0, 0, 0, 0, 0);
        gap(511); pls(1, 512, 1, 0, 0);

        // Longest interval that still reports instead of timing out.
        gap(1022); pls(1, 1023, 1, 1, 0);

        gap(5);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL missing_strobes: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
